// File: rtl/conv_window_scheduler_if.sv
// Window issue / result return handshake between the scheduler and the MAC engine.
interface conv_window_scheduler_if #(
  parameter int ADDR_W = 6
);
  logic              win_valid;
  logic              win_ready;
  logic [ADDR_W-1:0] win_base;
  logic              win_last;
  logic              res_valid;

  modport master (output win_valid, win_base, win_last, input win_ready, res_valid);
  modport slave  (input win_valid, win_base, win_last, output win_ready, res_valid);
endinterface

// File: rtl/conv_window_scheduler.sv
// Issues 3x3 window base addresses in row-major order, throttles windows in flight,
// and counts returned results until the whole output map is complete.
module conv_window_scheduler #(
  parameter int IFM_W        = 7,
  parameter int K            = 3,
  parameter int ADDR_W       = 6,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  conv_window_scheduler_if.master  win,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int OUT_W = IFM_W - K + 1;
  localparam int TOTAL = OUT_W * OUT_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int COL_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  results_q, results_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer, ret;

  assign xfer = valid_q & win.win_ready;
  assign ret  = win.res_valid;

  assign win.win_valid = valid_q;
  assign win.win_base  = base_q;
  assign win.win_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      base_q     <= '0;
      issued_q   <= '0;
      results_q  <= '0;
      inflight_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      base_q     <= base_d;
      issued_q   <= issued_d;
      results_q  <= results_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    base_d     = base_q;
    issued_d   = issued_q;
    results_d  = results_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (xfer && !ret)
      inflight_d = inflight_q + 1'b1;
    else if (!xfer && ret && inflight_q != '0)
      inflight_d = inflight_q - 1'b1;

    if (ret && (inflight_q == '0 || state_q == IDLE))
      err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        if (ret)
          results_d = results_q + 1'b1;
        if (xfer) begin
          issued_d = issued_q + 1'b1;
          // base holds on the final window so win_base still reads the last address
          if (issued_q == CNT_W'(TOTAL - 1)) begin
            state_d = DRAIN;
          end else if (col_q == COL_W'(OUT_W - 1)) begin
            col_d  = '0;
            base_d = base_q + ADDR_W'(K);
          end else begin
            col_d  = col_q + 1'b1;
            base_d = base_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (ret)
          results_d = results_q + 1'b1;
        if (results_d == CNT_W'(TOTAL))
          state_d = DONE;
      end
      DONE: begin
        state_d    = IDLE;
        col_d      = '0;
        base_d     = '0;
        issued_d   = '0;
        results_d  = '0;
        inflight_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      col_d      = '0;
      base_d     = '0;
      issued_d   = '0;
      results_d  = '0;
      inflight_d = '0;
      err_d      = err_q;
    end

    // registered outputs follow the next state, so a freed slot shows one cycle later
    valid_d = (state_d == ISSUE) && (inflight_d < IF_W'(MAX_INFLIGHT));
    last_d  = (state_d == ISSUE) && (issued_d == CNT_W'(TOTAL - 1));
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed passes with randomized handshake timing, checked against a
// window-order and outstanding-result model of the scheduler.
module tb_conv_window_scheduler;
  localparam int IFM_W        = 7;
  localparam int K            = 3;
  localparam int ADDR_W       = 6;
  localparam int MAX_INFLIGHT = 4;
  localparam int OUT_W        = IFM_W - K + 1;
  localparam int TOTAL        = OUT_W * OUT_W;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic err;

  conv_window_scheduler_if #(.ADDR_W(ADDR_W)) win_if ();

  conv_window_scheduler #(
    .IFM_W(IFM_W),
    .K(K),
    .ADDR_W(ADDR_W),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .win(win_if),
    .busy(busy),
    .done(done),
    .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_addr[$];
  int m_issued, m_inflight, m_results;
  bit m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    start              = 1'b0;
    abort              = 1'b0;
    win_if.res_valid   = 1'b0;
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random; delay < 0 means random latency
  task automatic run_pass(input int rdy_mode, input int delay, input bit inject_start,
                          input int abort_after);
    int due[$];
    bit issuing, exp_done, inj_iss, inj_drn, xfer, ret, exp_valid, rdy, abt;
    int ph, n, d;
    issuing  = 1'b1;
    exp_done = 1'b0;
    inj_iss  = 1'b0;
    inj_drn  = 1'b0;
    ph       = 0;
    n        = 0;
    start    = 1'b1;
    tick();
    m_err      = 1'b0;
    m_issued   = 0;
    m_inflight = 0;
    m_results  = 0;
    while (n < 3000) begin
      n++;
      exp_valid = issuing && (m_inflight < MAX_INFLIGHT);
      check("win_valid", win_if.win_valid, exp_valid);
      if (exp_valid) begin
        check("win_base", win_if.win_base, exp_addr[m_issued]);
        check("win_last", win_if.win_last, m_issued == TOTAL - 1);
      end
      check("busy", busy, !exp_done);
      check("done", done, exp_done);
      check("err", err, m_err);
      if (exp_done) begin
        if (inject_start) start = 1'b1;
        tick();
        check("done_once", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("valid_idle", win_if.win_valid, 1'b0);
        return;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      abt = (abort_after >= 0) && (m_issued == abort_after);
      ret = !abt && due.size() > 0 && due[0] <= cyc;
      win_if.win_ready = rdy;
      win_if.res_valid = ret;
      abort            = abt;
      if (inject_start && issuing && m_issued == 5 && !inj_iss) begin
        start   = 1'b1;
        inj_iss = 1'b1;
      end
      if (inject_start && !issuing && !inj_drn) begin
        start   = 1'b1;
        inj_drn = 1'b1;
      end
      xfer = exp_valid && rdy && !abt;
      d    = (delay < 0) ? int'($urandom_range(1, 8)) : delay;
      if (xfer) due.push_back(cyc + d);
      tick();
      if (abt) begin
        for (int i = 0; i < 4; i++) begin
          check("abort_valid", win_if.win_valid, 1'b0);
          check("abort_busy", busy, 1'b0);
          check("abort_done", done, 1'b0);
          check("abort_err", err, m_err);
          tick();
        end
        return;
      end
      if (xfer) begin
        m_issued++;
        m_inflight++;
      end
      if (ret) begin
        void'(due.pop_front());
        m_inflight--;
        m_results++;
      end
      if (m_issued == TOTAL) issuing = 1'b0;
      if (m_results == TOTAL) exp_done = 1'b1;
    end
    check("pass_timeout", n < 3000, 1'b1);
  endtask

  initial begin
    for (int r = 0; r < OUT_W; r++)
      for (int c = 0; c < OUT_W; c++)
        exp_addr.push_back(r * IFM_W + c);

    rst_n            = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    win_if.win_ready = 1'b0;
    win_if.res_valid = 1'b0;
    m_err            = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", win_if.win_valid, 1'b0);
    check("rst_base", win_if.win_base, 0);
    check("rst_last", win_if.win_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_pass(0, 3, 1'b0, -1);
    run_pass(1, 3, 1'b0, -1);
    run_pass(0, 10, 1'b0, -1);
    run_pass(0, 3, 1'b1, -1);
    run_pass(0, 3, 1'b0, 11);
    run_pass(0, 3, 1'b0, -1);

    win_if.res_valid = 1'b1;
    tick();
    m_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("err_sticky", err, m_err);
      check("err_idle_busy", busy, 1'b0);
      tick();
    end
    run_pass(2, -1, 1'b0, -1);
    run_pass(1, -1, 1'b0, -1);

    start = 1'b1;
    tick();
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", win_if.win_valid, 1'b0);
    check("midrst_base", win_if.win_base, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_valid", win_if.win_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
